// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: the fetch-tracking state
// and the bundle of stall/flush controls handed to the stage registers.
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    FS_IDLE    = 2'd0,
    FS_DISCARD = 2'd1
  } fetch_state_t;

  typedef struct packed {
    logic stall_pc;
    logic stall_f;
    logic stall_d;
    logic stall_e;
    logic stall_m;
    logic flush_d;
    logic flush_e;
    logic flush_m;
    logic flush_w;
  } hazard_ctl_t;

  localparam hazard_ctl_t HAZ_NONE = '0;

  // Held in reset: every stage register is loaded with a bubble, nothing is held.
  localparam hazard_ctl_t HAZ_RESET = '{
    stall_pc: 1'b0, stall_f: 1'b0, stall_d: 1'b0, stall_e: 1'b0, stall_m: 1'b0,
    flush_d:  1'b1, flush_e: 1'b1, flush_m: 1'b1, flush_w: 1'b1
  };

  function automatic logic any_stall(input hazard_ctl_t c);
    return c.stall_pc | c.stall_f | c.stall_d | c.stall_e | c.stall_m;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_perf_cnt.sv
// Debug/performance counters for the hazard controller: stall cycles and
// accepted redirects, both free-running and wrapping.
module hazard_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall_en,
  input  logic             redirect_en,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] redirect_cnt
);

  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0] redirect_cnt_q, redirect_cnt_d;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    redirect_cnt_d = redirect_cnt_q;
    if (stall_en)    stall_cycles_d = stall_cycles_q + 1'b1;
    if (redirect_en) redirect_cnt_d = redirect_cnt_q + 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cycles_q <= '0;
      redirect_cnt_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      redirect_cnt_q <= redirect_cnt_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign redirect_cnt = redirect_cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller for the F/D/E/M/W pipeline: resolves bus waits,
// load-use hazards and execute redirects, and discards stale fetch beats.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int CNT_W  = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req_valid,
  input  logic              i_data_ok,
  input  logic              d_req_valid,
  input  logic              d_data_ok,
  input  logic [REG_AW-1:0] d_ra1,
  input  logic [REG_AW-1:0] d_ra2,
  input  logic              d_use1,
  input  logic              d_use2,
  input  logic [REG_AW-1:0] e_rd,
  input  logic              e_memread,
  input  logic              e_redirect,
  output logic              stall_pc,
  output logic              stall_f,
  output logic              stall_d,
  output logic              stall_e,
  output logic              stall_m,
  output logic              flush_d,
  output logic              flush_e,
  output logic              flush_m,
  output logic              flush_w,
  output logic              fetch_discard,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  redirect_cnt
);

  fetch_state_t state_q, state_d;
  hazard_ctl_t  ctl;
  logic         mem_wait, fetch_wait, load_use, redirect_take;

  assign mem_wait   = d_req_valid && !d_data_ok;
  assign fetch_wait = (i_req_valid && !i_data_ok) || (state_q == FS_DISCARD);
  assign load_use   = e_memread && (e_rd != '0) &&
                      ((d_use1 && (d_ra1 == e_rd)) || (d_use2 && (d_ra2 == e_rd)));

  always_comb begin
    ctl           = HAZ_NONE;
    state_d       = state_q;
    fetch_discard = 1'b0;
    redirect_take = 1'b0;
    if (!reset) begin
      ctl = HAZ_RESET;
    end else begin
      if (state_q == FS_DISCARD) begin
        fetch_discard = i_data_ok;
        if (i_data_ok) state_d = FS_IDLE;
      end
      // A memory wait freezes E, so any redirect/load-use there is re-presented later.
      if (mem_wait) begin
        ctl.stall_pc = 1'b1;
        ctl.stall_f  = 1'b1;
        ctl.stall_d  = 1'b1;
        ctl.stall_e  = 1'b1;
        ctl.stall_m  = 1'b1;
        ctl.flush_w  = 1'b1;
      end else if (e_redirect) begin
        ctl.flush_d   = 1'b1;
        ctl.flush_e   = 1'b1;
        redirect_take = 1'b1;
        if (state_q == FS_IDLE) begin
          // A beat landing now or later for the old PC belongs to the wrong path.
          fetch_discard = i_data_ok;
          if (fetch_wait) begin
            ctl.stall_f = 1'b1;
            state_d     = FS_DISCARD;
          end
        end
      end else if (load_use) begin
        ctl.stall_pc = 1'b1;
        ctl.stall_f  = 1'b1;
        ctl.stall_d  = 1'b1;
        ctl.flush_e  = 1'b1;
      end else if (fetch_wait) begin
        ctl.stall_pc = 1'b1;
        ctl.stall_f  = 1'b1;
        ctl.flush_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) state_q <= FS_IDLE;
    else        state_q <= state_d;
  end

  assign stall_pc = ctl.stall_pc;
  assign stall_f  = ctl.stall_f;
  assign stall_d  = ctl.stall_d;
  assign stall_e  = ctl.stall_e;
  assign stall_m  = ctl.stall_m;
  assign flush_d  = ctl.flush_d;
  assign flush_e  = ctl.flush_e;
  assign flush_m  = ctl.flush_m;
  assign flush_w  = ctl.flush_w;

  hazard_perf_cnt #(.CNT_W(CNT_W)) u_perf (
    .clk          (clk),
    .reset        (reset),
    .stall_en     (any_stall(ctl)),
    .redirect_en  (redirect_take),
    .stall_cycles (stall_cycles),
    .redirect_cnt (redirect_cnt)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios with literal
// expectations, then randomized traffic compared against a rule-level model.
module tb_pipe_hazard_ctrl;

  localparam int CNT_W  = 32;
  localparam int REG_AW = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic              i_req_valid, i_data_ok, d_req_valid, d_data_ok;
  logic [REG_AW-1:0] d_ra1, d_ra2, e_rd;
  logic              d_use1, d_use2, e_memread, e_redirect;
  logic              stall_pc, stall_f, stall_d, stall_e, stall_m;
  logic              flush_d, flush_e, flush_m, flush_w, fetch_discard;
  logic [CNT_W-1:0]  stall_cycles, redirect_cnt;

  int total = 0;
  int bad   = 0;

  pipe_hazard_ctrl #(.CNT_W(CNT_W), .REG_AW(REG_AW)) dut (
    .clk(clk), .reset(reset),
    .i_req_valid(i_req_valid), .i_data_ok(i_data_ok),
    .d_req_valid(d_req_valid), .d_data_ok(d_data_ok),
    .d_ra1(d_ra1), .d_ra2(d_ra2), .d_use1(d_use1), .d_use2(d_use2),
    .e_rd(e_rd), .e_memread(e_memread), .e_redirect(e_redirect),
    .stall_pc(stall_pc), .stall_f(stall_f), .stall_d(stall_d),
    .stall_e(stall_e), .stall_m(stall_m),
    .flush_d(flush_d), .flush_e(flush_e), .flush_m(flush_m), .flush_w(flush_w),
    .fetch_discard(fetch_discard),
    .stall_cycles(stall_cycles), .redirect_cnt(redirect_cnt)
  );

  always #5 clk = ~clk;

  // Output vector order: stall_pc,f,d,e,m | flush_d,e,m,w | fetch_discard
  function automatic logic [9:0] dut_vec();
    return {stall_pc, stall_f, stall_d, stall_e, stall_m,
            flush_d, flush_e, flush_m, flush_w, fetch_discard};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_discard;   // a redirected fetch beat is still owed by the bus
  logic [31:0] m_stall, m_redir;
  bit          m_valid = 1'b0;

  function automatic logic [9:0] model_out();
    bit mw, fw, lu, held;
    logic [9:0] v;
    mw   = d_req_valid && !d_data_ok;
    fw   = (i_req_valid && !i_data_ok) || m_discard;
    lu   = e_memread && (e_rd != 0) &&
           ((d_use1 && d_ra1 == e_rd) || (d_use2 && d_ra2 == e_rd));
    held = (reset == 1'b0);
    v = '0;
    if (held)            v = 10'b00000_1111_0;
    else if (mw)         v = 10'b11111_0001_0;
    else if (e_redirect) v = (fw && !m_discard) ? 10'b01000_1100_0 : 10'b00000_1100_0;
    else if (lu)         v = 10'b11100_0100_0;
    else if (fw)         v = 10'b11000_1000_0;
    if (!held) begin
      if (m_discard) v[0] = i_data_ok;
      else if (e_redirect && !mw) v[0] = i_data_ok;
    end
    return v;
  endfunction

  always @(posedge clk) begin
    logic [9:0] v;
    v = model_out();
    if (!reset) begin
      m_discard = 1'b0;
      m_stall   = '0;
      m_redir   = '0;
      m_valid   = 1'b1;
    end else if (m_valid) begin
      if (|v[9:5]) m_stall = m_stall + 1;
      if (e_redirect && !(d_req_valid && !d_data_ok)) m_redir = m_redir + 1;
      if (m_discard) m_discard = !i_data_ok;
      else m_discard = e_redirect && i_req_valid && !i_data_ok && !(d_req_valid && !d_data_ok);
    end
  end

  // Compare process: every cycle once the model has seen a reset edge.
  string names [10] = '{"stall_pc", "stall_f", "stall_d", "stall_e", "stall_m",
                        "flush_d", "flush_e", "flush_m", "flush_w", "fetch_discard"};
  always @(negedge clk) begin
    if (m_valid) begin
      logic [9:0] e, a;
      e = model_out();
      a = dut_vec();
      for (int i = 0; i < 10; i++) check(names[i], 32'(a[9-i]), 32'(e[9-i]));
      check("stall_cycles", stall_cycles, m_stall);
      check("redirect_cnt", redirect_cnt, m_redir);
    end
  end

  // ---------------- stimulus ----------------
  task automatic clr();
    i_req_valid = 0; i_data_ok = 0; d_req_valid = 0; d_data_ok = 0;
    d_ra1 = 0; d_ra2 = 0; d_use1 = 0; d_use2 = 0;
    e_rd = 0; e_memread = 0; e_redirect = 0;
  endtask

  task automatic next();
    @(posedge clk); #1; clr();
  endtask

  task automatic lit(input string name, input logic [9:0] exp);
    @(negedge clk);
    check(name, 32'(dut_vec()), 32'(exp));
  endtask

  initial begin
    clr();
    reset = 1'b0;
    lit("reset_outputs", 10'b00000_1111_0);
    next(); reset = 1'b1;
    lit("idle_clean", 10'b0);
    check("cnt_after_reset", stall_cycles, 32'd0);

    // Memory wait for three cycles, released on the fourth.
    for (int i = 0; i < 3; i++) begin
      next(); d_req_valid = 1;
      lit("mem_wait", 10'b11111_0001_0);
    end
    next(); d_req_valid = 1; d_data_ok = 1;
    lit("mem_done_clean", 10'b0);
    check("stall_cycles_3", stall_cycles, 32'd3);

    // Load-use on rs1, then the same with x0 as destination.
    next(); e_memread = 1; e_rd = 5; d_ra1 = 5; d_use1 = 1;
    lit("load_use", 10'b11100_0100_0);
    next(); e_memread = 1; e_rd = 0; d_ra1 = 0; d_use1 = 1;
    lit("load_use_x0", 10'b0);

    // Redirect mid-fetch, stale beat arrives two cycles later.
    next(); e_redirect = 1; i_req_valid = 1;
    lit("redir_midfetch", 10'b01000_1100_0);
    next();
    lit("discard_wait", 10'b11000_1000_0);
    next(); i_req_valid = 1; i_data_ok = 1;
    lit("discard_beat", 10'b11000_1000_1);
    next();
    lit("back_idle", 10'b0);
    check("redirect_cnt_1", redirect_cnt, 32'd1);
    check("stall_cycles_7", stall_cycles, 32'd7);

    // Redirect masked by memory wait, honoured once the data arrives.
    next(); e_redirect = 1; d_req_valid = 1;
    lit("redir_under_mw", 10'b11111_0001_0);
    next(); e_redirect = 1; d_req_valid = 1; d_data_ok = 1;
    lit("redir_after_mw", 10'b00000_1100_0);
    check("redirect_cnt_held", redirect_cnt, 32'd1);

    // Load-use coinciding with a fetch wait keeps D valid.
    next(); e_memread = 1; e_rd = 7; d_ra2 = 7; d_use2 = 1; i_req_valid = 1;
    lit("lu_and_fetch_wait", 10'b11100_0100_0);
    check("redirect_cnt_2", redirect_cnt, 32'd2);

    // Redirect with the beat landing the same cycle: discarded, no DISCARD state.
    next(); e_redirect = 1; i_req_valid = 1; i_data_ok = 1;
    lit("redir_same_beat", 10'b00000_1100_1);
    next();
    lit("no_discard_state", 10'b0);

    // Enter DISCARD, then hold reset for two cycles.
    next(); e_redirect = 1; i_req_valid = 1;
    lit("redir_before_rst", 10'b01000_1100_0);
    next(); reset = 0;
    lit("rst_in_discard", 10'b00000_1111_0);
    next(); reset = 0;
    lit("rst_hold", 10'b00000_1111_0);
    next(); reset = 1;
    lit("after_rst_idle", 10'b0);
    check("rst_stall_cnt", stall_cycles, 32'd0);
    check("rst_redir_cnt", redirect_cnt, 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      reset       = ($urandom_range(99) >= 2);
      i_req_valid = ($urandom_range(99) < 70);
      i_data_ok   = ($urandom_range(99) < 40);
      d_req_valid = ($urandom_range(99) < 30);
      d_data_ok   = ($urandom_range(99) < 50);
      d_ra1       = REG_AW'($urandom_range(3));
      d_ra2       = REG_AW'($urandom_range(3));
      d_use1      = ($urandom_range(99) < 60);
      d_use2      = ($urandom_range(99) < 60);
      e_rd        = REG_AW'($urandom_range(3));
      e_memread   = ($urandom_range(99) < 30);
      e_redirect  = ($urandom_range(99) < 15);
    end

    @(posedge clk); #1; clr(); reset = 1;
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
